// File: rtl/regfile_mp_pkg.sv
// regfile_mp_pkg
//   Shared defaults for the multi-port register file: data/address widths,
//   register count, and the bring-up values loaded into r1/r2 on reset.
package regfile_mp_pkg;

  localparam int DSIZE_DEF = 16;
  localparam int ASIZE_DEF = 4;
  localparam int NREG_DEF  = 16;

  // Bring-up init values held by r1/r2 after reset
  localparam int INIT_R1 = 5;
  localparam int INIT_R2 = 2;

  // Reset value of register idx
  function automatic int init_val(input int idx);
    case (idx)
      1:       return INIT_R1;
      2:       return INIT_R2;
      default: return 0;
    endcase
  endfunction

endpackage

// File: rtl/regfile_mp_if.sv
// regfile_mp_if
//   Bundles the write, read and scoreboard signals of regfile_mp.
//   master : issue/writeback side (drives writes, reads, reservations)
//   slave  : register file side (returns rdata, rbusy, busy_cnt)
//   wen/waddr/wdata : NWR write ports, port k at slice k
//   raddr/rdata/rbusy : NRD read ports, port j at slice j
//   rsv_en/rsv_addr : destination reservation from issue
//   busy_cnt : registered count of busy registers
interface regfile_mp_if #(
  parameter int DSIZE = 16,
  parameter int ASIZE = 4,
  parameter int NRD   = 2,
  parameter int NWR   = 2
);
  logic [NWR-1:0]       wen;
  logic [NWR*ASIZE-1:0] waddr;
  logic [NWR*DSIZE-1:0] wdata;
  logic [NRD*ASIZE-1:0] raddr;
  logic [NRD*DSIZE-1:0] rdata;
  logic [NRD-1:0]       rbusy;
  logic                 rsv_en;
  logic [ASIZE-1:0]     rsv_addr;
  logic [ASIZE:0]       busy_cnt;

  modport master (
    output wen, waddr, wdata, raddr, rsv_en, rsv_addr,
    input  rdata, rbusy, busy_cnt
  );

  modport slave (
    input  wen, waddr, wdata, raddr, rsv_en, rsv_addr,
    output rdata, rbusy, busy_cnt
  );
endinterface

// File: rtl/regfile_fwd_mux.sv
// regfile_fwd_mux
//   Priority forwarding mux for one read port: scans all write ports and
//   returns the data of the highest-index enabled port whose address matches.
//   i_wen/i_waddr/i_wdata : all write ports (packed, port k at slice k)
//   i_raddr               : read address
//   o_data                : forwarded data (0 when no hit)
//   o_hit                 : some enabled write port targets i_raddr
module regfile_fwd_mux #(
  parameter int DSIZE = 16,
  parameter int ASIZE = 4,
  parameter int NWR   = 2
) (
  input  logic [NWR-1:0]       i_wen,
  input  logic [NWR*ASIZE-1:0] i_waddr,
  input  logic [NWR*DSIZE-1:0] i_wdata,
  input  logic [ASIZE-1:0]     i_raddr,
  output logic [DSIZE-1:0]     o_data,
  output logic                 o_hit
);

  // Ascending scan: a later (higher-index) match overrides an earlier one
  always_comb begin
    o_data = '0;
    o_hit  = 1'b0;
    for (int k = 0; k < NWR; k++) begin
      if (i_wen[k] && (i_waddr[k*ASIZE +: ASIZE] == i_raddr)) begin
        o_data = i_wdata[k*DSIZE +: DSIZE];
        o_hit  = 1'b1;
      end
    end
  end

endmodule

// File: rtl/regfile_mp.sv
// regfile_mp
//   Multi-port register file with NRD combinational read ports, NWR
//   synchronous write ports, same-cycle write-to-read forwarding and a
//   per-register busy scoreboard for the hazard unit.
//   clk  : rising-edge clock
//   rst  : asynchronous active-low reset
//   bus  : regfile_mp_if slave (write/read ports, reservation, busy_cnt)
module regfile_mp
  import regfile_mp_pkg::*;
#(
  parameter int DSIZE   = DSIZE_DEF,
  parameter int ASIZE   = ASIZE_DEF,
  parameter int NREG    = NREG_DEF,
  parameter int NRD     = 2,
  parameter int NWR     = 2,
  parameter int ZERO_R0 = 1
) (
  input  logic         clk,
  input  logic         rst,
  regfile_mp_if.slave  bus
);

  logic [DSIZE-1:0] r_mem [NREG];
  logic [NREG-1:0]  r_busy;
  logic [ASIZE:0]   r_busy_cnt;

  logic [NWR-1:0]   w_wen;
  logic [NREG-1:0]  w_busy_nxt;
  logic [ASIZE:0]   w_busy_cnt_nxt;
  logic [ASIZE-1:0] w_raddr    [NRD];
  logic [DSIZE-1:0] w_fwd_data [NRD];
  logic [NRD-1:0]   w_fwd_hit;

  // Address names a real, writable register (excludes r0 when hardwired)
  function automatic logic addr_ok(input logic [ASIZE-1:0] a);
    return (int'(a) < NREG) && !((ZERO_R0 != 0) && (a == '0));
  endfunction

  // Forwarding is suppressed while reset is held
  assign w_wen = bus.wen & {NWR{rst}};

  // Register array; ascending port loop lets the highest index win
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < NREG; i++) r_mem[i] <= DSIZE'(init_val(i));
    end else begin
      for (int k = 0; k < NWR; k++) begin
        if (w_wen[k] && addr_ok(bus.waddr[k*ASIZE +: ASIZE]))
          r_mem[bus.waddr[k*ASIZE +: ASIZE]] <= bus.wdata[k*DSIZE +: DSIZE];
      end
    end
  end

  // Scoreboard next state: writebacks clear first, then a reservation sets,
  // so a same-cycle reserve+write leaves the newer instruction owning it
  always_comb begin
    w_busy_nxt = r_busy;
    for (int k = 0; k < NWR; k++) begin
      if (w_wen[k] && addr_ok(bus.waddr[k*ASIZE +: ASIZE]))
        w_busy_nxt[bus.waddr[k*ASIZE +: ASIZE]] = 1'b0;
    end
    if (bus.rsv_en && addr_ok(bus.rsv_addr))
      w_busy_nxt[bus.rsv_addr] = 1'b1;
  end

  always_comb begin
    w_busy_cnt_nxt = '0;
    for (int i = 0; i < NREG; i++)
      w_busy_cnt_nxt = w_busy_cnt_nxt + {{ASIZE{1'b0}}, w_busy_nxt[i]};
  end

  // Count is registered alongside the busy vector so both move together
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_busy     <= '0;
      r_busy_cnt <= '0;
    end else begin
      r_busy     <= w_busy_nxt;
      r_busy_cnt <= w_busy_cnt_nxt;
    end
  end

  assign bus.busy_cnt = r_busy_cnt;

  for (genvar j = 0; j < NRD; j++) begin : g_rd
    assign w_raddr[j] = bus.raddr[j*ASIZE +: ASIZE];

    regfile_fwd_mux #(
      .DSIZE (DSIZE),
      .ASIZE (ASIZE),
      .NWR   (NWR)
    ) u_fwd (
      .i_wen   (w_wen),
      .i_waddr (bus.waddr),
      .i_wdata (bus.wdata),
      .i_raddr (w_raddr[j]),
      .o_data  (w_fwd_data[j]),
      .o_hit   (w_fwd_hit[j])
    );
  end

  // A forwarded value is usable, so a hit masks the busy bit
  always_comb begin
    bus.rdata = '0;
    bus.rbusy = '0;
    for (int j = 0; j < NRD; j++) begin
      if (addr_ok(w_raddr[j])) begin
        bus.rdata[j*DSIZE +: DSIZE] = w_fwd_hit[j] ? w_fwd_data[j] : r_mem[w_raddr[j]];
        bus.rbusy[j] = r_busy[w_raddr[j]] & ~w_fwd_hit[j];
      end
    end
  end

endmodule

// File: tb/tb_regfile_mp.sv
// tb_regfile_mp
//   Scoreboard bench for regfile_mp: expected outputs are queued when
//   stimulus is driven and popped/compared when the outputs are sampled.
module tb_regfile_mp;

  localparam int DSIZE = 16;
  localparam int ASIZE = 4;
  localparam int NRD   = 2;
  localparam int NWR   = 2;

  logic clk;
  logic rst;

  regfile_mp_if #(.DSIZE(DSIZE), .ASIZE(ASIZE), .NRD(NRD), .NWR(NWR)) bus ();

  regfile_mp #(
    .DSIZE(DSIZE), .ASIZE(ASIZE), .NREG(16), .NRD(NRD), .NWR(NWR), .ZERO_R0(1)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef enum int {K_RD0, K_RD1, K_BSY0, K_BSY1, K_CNT} kind_e;
  typedef struct {
    string       tag;
    kind_e       kind;
    logic [31:0] exp;
  } exp_t;

  exp_t sb_q[$];
  int   n_checks = 0;
  int   n_err    = 0;

  task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  function automatic logic [31:0] observe(input kind_e k);
    case (k)
      K_RD0:   return {16'h0, bus.rdata[15:0]};
      K_RD1:   return {16'h0, bus.rdata[31:16]};
      K_BSY0:  return {31'h0, bus.rbusy[0]};
      K_BSY1:  return {31'h0, bus.rbusy[1]};
      default: return {27'h0, bus.busy_cnt};
    endcase
  endfunction

  task automatic expect_out(input string tag, input kind_e k, input logic [31:0] v);
    exp_t e;
    e.tag  = tag;
    e.kind = k;
    e.exp  = v;
    sb_q.push_back(e);
  endtask

  task automatic drain();
    exp_t e;
    while (sb_q.size() > 0) begin
      e = sb_q.pop_front();
      check_val(e.tag, observe(e.kind), e.exp);
    end
  endtask

  task automatic sample();
    @(negedge clk);
    drain();
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bus.wen      = '0;
    bus.waddr    = '0;
    bus.wdata    = '0;
    bus.rsv_en   = 1'b0;
    bus.rsv_addr = '0;
  endtask

  task automatic wr(input int port, input logic [3:0] addr, input logic [15:0] data);
    bus.wen[port]             = 1'b1;
    bus.waddr[port*4 +: 4]    = addr;
    bus.wdata[port*16 +: 16]  = data;
  endtask

  task automatic rd(input int port, input logic [3:0] addr);
    bus.raddr[port*4 +: 4] = addr;
  endtask

  task automatic rsv(input logic [3:0] addr);
    bus.rsv_en   = 1'b1;
    bus.rsv_addr = addr;
  endtask

  int model_cnt;

  initial begin
    rst = 1'b1;
    bus.raddr = '0;
    idle();
    #1 rst = 1'b0;
    rd(0, 1); rd(1, 2);
    #1;
    expect_out("rst0_r1", K_RD0, 32'h5);
    expect_out("rst0_r2", K_RD1, 32'h2);
    expect_out("rst0_cnt", K_CNT, 32'h0);
    expect_out("rst0_bsy", K_BSY0, 32'h0);
    drain();
    next_cycle();
    next_cycle();
    rst = 1'b1;

    // Activity before a mid-cycle reset
    wr(0, 1, 16'h1234); rsv(6);
    next_cycle(); idle();
    rd(0, 1); rd(1, 6);
    expect_out("pre_r1", K_RD0, 32'h1234);
    expect_out("pre_bsy6", K_BSY1, 32'h1);
    expect_out("pre_cnt", K_CNT, 32'h1);
    sample();
    next_cycle();
    wr(0, 3, 16'hAAAA); rd(0, 3); rd(1, 1);
    #1;
    expect_out("pre_fwd3", K_RD0, 32'hAAAA);
    drain();
    #1 rst = 1'b0;
    #1;
    expect_out("mrst_nofwd", K_RD0, 32'h0);
    expect_out("mrst_r1", K_RD1, 32'h5);
    expect_out("mrst_cnt", K_CNT, 32'h0);
    expect_out("mrst_bsy", K_BSY0, 32'h0);
    drain();
    next_cycle(); idle();
    rd(0, 2); rd(1, 6);
    #1;
    expect_out("mrst_r2", K_RD0, 32'h2);
    expect_out("mrst_bsy6", K_BSY1, 32'h0);
    drain();
    next_cycle();
    rst = 1'b1;

    // Forwarding priority
    idle();
    wr(0, 3, 16'h1111); wr(1, 3, 16'hBEEF); rd(0, 3); rd(1, 3);
    expect_out("fwd_p1_rd0", K_RD0, 32'hBEEF);
    expect_out("fwd_p1_rd1", K_RD1, 32'hBEEF);
    expect_out("fwd_bsy", K_BSY0, 32'h0);
    sample();
    next_cycle(); idle();
    wr(0, 4, 16'h4444); rd(0, 3); rd(1, 4);
    expect_out("store_r3", K_RD0, 32'hBEEF);
    expect_out("fwd_p0_r4", K_RD1, 32'h4444);
    sample();
    next_cycle(); idle();
    expect_out("store_r3b", K_RD0, 32'hBEEF);
    expect_out("store_r4", K_RD1, 32'h4444);
    sample();

    // Zero register
    next_cycle(); idle();
    wr(0, 0, 16'h00FF); rsv(0); rd(0, 0);
    expect_out("r0_fwd", K_RD0, 32'h0);
    expect_out("r0_bsy", K_BSY0, 32'h0);
    sample();
    next_cycle(); idle();
    expect_out("r0_cnt", K_CNT, 32'h0);
    expect_out("r0_rd", K_RD0, 32'h0);
    expect_out("r0_bsy2", K_BSY0, 32'h0);
    sample();

    // Scoreboard lifecycle on r5
    next_cycle(); idle();
    rsv(5); rd(0, 5);
    expect_out("r5_bsy_pre", K_BSY0, 32'h0);
    sample();
    next_cycle(); idle();
    expect_out("r5_cnt1", K_CNT, 32'h1);
    expect_out("r5_bsy1", K_BSY0, 32'h1);
    expect_out("r5_rd0", K_RD0, 32'h0);
    sample();
    next_cycle(); idle();
    wr(0, 5, 16'h0042);
    expect_out("r5_wb_bsy", K_BSY0, 32'h0);
    expect_out("r5_wb_rd", K_RD0, 32'h0042);
    expect_out("r5_wb_cnt", K_CNT, 32'h1);
    sample();
    next_cycle(); idle();
    expect_out("r5_cnt0", K_CNT, 32'h0);
    expect_out("r5_bsy0", K_BSY0, 32'h0);
    expect_out("r5_rd", K_RD0, 32'h0042);
    sample();

    // Simultaneous reserve and write on r7
    next_cycle(); idle();
    wr(0, 7, 16'h7777); rsv(7); rd(0, 7);
    expect_out("r7_fwd", K_RD0, 32'h7777);
    expect_out("r7_bsy_pre", K_BSY0, 32'h0);
    sample();
    next_cycle(); idle();
    expect_out("r7_cnt", K_CNT, 32'h1);
    expect_out("r7_bsy", K_BSY0, 32'h1);
    expect_out("r7_rd", K_RD0, 32'h7777);
    sample();
    next_cycle(); idle();
    wr(1, 7, 16'h7070);
    expect_out("r7_wb_bsy", K_BSY0, 32'h0);
    expect_out("r7_wb_rd", K_RD0, 32'h7070);
    sample();
    next_cycle(); idle();
    expect_out("r7_cnt0", K_CNT, 32'h0);
    expect_out("r7_rd2", K_RD0, 32'h7070);
    sample();

    // Fill r1..r15
    model_cnt = 0;
    for (int i = 1; i < 16; i++) begin
      next_cycle(); idle();
      rsv(4'(i)); rd(0, 4'(i));
      next_cycle(); idle();
      model_cnt++;
      expect_out($sformatf("fill_cnt%0d", i), K_CNT, 32'(model_cnt));
      expect_out($sformatf("fill_bsy%0d", i), K_BSY0, 32'h1);
      sample();
    end
    next_cycle(); idle();
    rsv(4);
    next_cycle(); idle();
    expect_out("rersv_cnt", K_CNT, 32'(model_cnt));
    sample();
    next_cycle(); idle();
    rsv(0);
    next_cycle(); idle();
    expect_out("rsv0_cnt", K_CNT, 32'(model_cnt));
    sample();
    next_cycle(); idle();
    wr(0, 1, 16'h0101); wr(1, 2, 16'h0202); rd(0, 1); rd(1, 2);
    expect_out("dual_bsy0", K_BSY0, 32'h0);
    expect_out("dual_bsy1", K_BSY1, 32'h0);
    sample();
    next_cycle(); idle();
    model_cnt = model_cnt - 2;
    expect_out("dual_cnt", K_CNT, 32'(model_cnt));
    expect_out("dual_r1", K_RD0, 32'h0101);
    expect_out("dual_r2", K_RD1, 32'h0202);
    sample();
    rd(0, 1); rd(1, 4);
    #2 rst = 1'b0;
    #1;
    expect_out("fill_rst_cnt", K_CNT, 32'h0);
    expect_out("fill_rst_bsy4", K_BSY1, 32'h0);
    expect_out("fill_rst_r1", K_RD0, 32'h5);
    drain();
    next_cycle();
    rst = 1'b1;
    next_cycle();

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
